// File: rtl/nn_key_debounce_if.sv
// Key conditioner signal bundle: raw pins and clears in, clean levels/pulses/flags out.
interface nn_key_debounce_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] KEY_RAW;
    logic [KEY_NUM-1:0] EVENT_CLR;
    logic [KEY_NUM-1:0] KEY_OUT;
    logic [KEY_NUM-1:0] KEY_PRESS;
    logic [KEY_NUM-1:0] KEY_RELEASE;
    logic [KEY_NUM-1:0] KEY_EVENT;

    modport master (
        output KEY_RAW, EVENT_CLR,
        input  KEY_OUT, KEY_PRESS, KEY_RELEASE, KEY_EVENT
    );

    modport slave (
        input  KEY_RAW, EVENT_CLR,
        output KEY_OUT, KEY_PRESS, KEY_RELEASE, KEY_EVENT
    );
endinterface

// File: rtl/nn_key_debounce.sv
// Per-key two-flop synchroniser and counter debouncer feeding the core KEY input,
// with registered press/release pulses and sticky press flags.
module nn_key_debounce #(
    parameter int KEY_NUM         = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input logic               CLK,
    input logic               RST_N,
    nn_key_debounce_if.slave  kif
);

    localparam logic               ACT_LOW  = (KEY_ACTIVE_LOW != 0);
    localparam logic [KEY_NUM-1:0] IDLE_PIN = {KEY_NUM{ACT_LOW}};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_NUM-1:0] sync1_q, sync1_d;
    logic [KEY_NUM-1:0] sync2_q, sync2_d;
    logic [KEY_NUM-1:0] stable_q, stable_d;
    logic [KEY_NUM-1:0] press_q, press_d;
    logic [KEY_NUM-1:0] release_q, release_d;
    logic [KEY_NUM-1:0] event_q, event_d;
    logic [CNT_W-1:0]   cnt_q [KEY_NUM];
    logic [CNT_W-1:0]   cnt_d [KEY_NUM];
    logic [KEY_NUM-1:0] pressed;

    always_comb begin
        sync1_d   = kif.KEY_RAW;
        sync2_d   = sync1_q;
        pressed   = sync2_q ^ IDLE_PIN;
        stable_d  = stable_q;
        for (int i = 0; i < KEY_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pressed[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = pressed[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Pulses are registered alongside stable so they line up with KEY_OUT's first new cycle
        press_d   = stable_d & ~stable_q;
        release_d = ~stable_d & stable_q;
        event_d   = press_d | (event_q & ~kif.EVENT_CLR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q   <= IDLE_PIN;
            sync2_q   <= IDLE_PIN;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            event_q   <= '0;
            for (int i = 0; i < KEY_NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            event_q   <= event_d;
            for (int i = 0; i < KEY_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign kif.KEY_OUT     = stable_q;
    assign kif.KEY_PRESS   = press_q;
    assign kif.KEY_RELEASE = release_q;
    assign kif.KEY_EVENT   = event_q;

endmodule

// File: tb/tb_nn_key_debounce.sv
// Directed bench for nn_key_debounce with DEBOUNCE_CYCLES=4, active-low pins, 4 keys.
module tb_nn_key_debounce;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] acc;
    int   npress;

    nn_key_debounce_if #(.KEY_NUM(4)) kif ();

    nn_key_debounce #(
        .KEY_NUM(4), .DEBOUNCE_CYCLES(4), .CNT_W(16), .KEY_ACTIVE_LOW(1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .kif   (kif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit so outputs reflect that edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RST_N         = 1'b0;
        kif.KEY_RAW   = 4'b0000;
        kif.EVENT_CLR = 4'b0000;
        ticks(3);
        chk("rst_out", kif.KEY_OUT, 4'h0);
        chk("rst_press", kif.KEY_PRESS, 4'h0);
        chk("rst_release", kif.KEY_RELEASE, 4'h0);
        chk("rst_event", kif.KEY_EVENT, 4'h0);

        // Reset release with all keys held: accepted 6 edges later (first sampling edge + 5)
        RST_N = 1'b1;
        ticks(5);
        chk("rst_hold_out", kif.KEY_OUT, 4'h0);
        chk("rst_hold_press", kif.KEY_PRESS, 4'h0);
        tick();
        chk("rst_acc_out", kif.KEY_OUT, 4'hF);
        chk("rst_acc_press", kif.KEY_PRESS, 4'hF);
        chk("rst_acc_event", kif.KEY_EVENT, 4'hF);
        tick();
        chk("rst_press_end", kif.KEY_PRESS, 4'h0);
        chk("rst_out_hold", kif.KEY_OUT, 4'hF);

        // Release everything, then clear all flags
        kif.KEY_RAW = 4'hF;
        ticks(5);
        chk("relall_pre", kif.KEY_RELEASE, 4'h0);
        tick();
        chk("relall_pulse", kif.KEY_RELEASE, 4'hF);
        chk("relall_out", kif.KEY_OUT, 4'h0);
        chk("relall_event", kif.KEY_EVENT, 4'hF);
        kif.EVENT_CLR = 4'hF;
        tick();
        kif.EVENT_CLR = 4'h0;
        chk("clr_all", kif.KEY_EVENT, 4'h0);
        chk("relall_end", kif.KEY_RELEASE, 4'h0);
        ticks(2);

        // Clean press on key 0
        kif.KEY_RAW = 4'b1110;
        ticks(5);
        chk("p0_early", kif.KEY_OUT, 4'h0);
        tick();
        chk("p0_out", kif.KEY_OUT, 4'h1);
        chk("p0_press", kif.KEY_PRESS, 4'h1);
        chk("p0_event", kif.KEY_EVENT, 4'h1);
        tick();
        chk("p0_press_end", kif.KEY_PRESS, 4'h0);
        chk("p0_out_hold", kif.KEY_OUT, 4'h1);
        ticks(2);

        // Release key 0
        kif.KEY_RAW = 4'hF;
        ticks(5);
        chk("r0_early", kif.KEY_RELEASE, 4'h0);
        tick();
        chk("r0_pulse", kif.KEY_RELEASE, 4'h1);
        chk("r0_nopress", kif.KEY_PRESS, 4'h0);
        chk("r0_out", kif.KEY_OUT, 4'h0);
        chk("r0_event", kif.KEY_EVENT, 4'h1);
        tick();
        chk("r0_end", kif.KEY_RELEASE, 4'h0);
        ticks(2);

        // Bounce on key 1: 3-cycle lows must never be accepted
        acc = 4'h0;
        for (int b = 0; b < 5; b++) begin
            kif.KEY_RAW = 4'b1101;
            for (int i = 0; i < 3; i++) begin
                tick();
                acc = acc | kif.KEY_OUT | kif.KEY_PRESS | kif.KEY_EVENT;
            end
            kif.KEY_RAW = 4'hF;
            for (int i = 0; i < 3; i++) begin
                tick();
                acc = acc | kif.KEY_OUT | kif.KEY_PRESS | kif.KEY_EVENT;
            end
        end
        ticks(3);
        acc = acc | kif.KEY_OUT | kif.KEY_PRESS | kif.KEY_EVENT;
        chk("bounce_k1", {31'd0, acc[1]}, 32'd0);

        // Then a 6-cycle low on key 1 is accepted exactly once
        npress = 0;
        kif.KEY_RAW = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (kif.KEY_PRESS[1]) npress++;
        end
        kif.KEY_RAW = 4'hF;
        tick();
        if (kif.KEY_PRESS[1]) npress++;
        chk("k1_out", kif.KEY_OUT, 4'h2);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (kif.KEY_PRESS[1]) npress++;
        end
        chk("k1_npress", npress, 1);
        chk("k1_event", kif.KEY_EVENT, 4'h3);
        chk("k1_released", kif.KEY_OUT, 4'h0);

        // Sticky clear race on key 2
        kif.KEY_RAW = 4'b1011;
        ticks(5);
        kif.EVENT_CLR = 4'b0100;
        tick();
        chk("race_press", kif.KEY_PRESS, 4'h4);
        chk("race_event", {31'd0, kif.KEY_EVENT[2]}, 32'd1);
        tick();
        kif.EVENT_CLR = 4'h0;
        chk("race_clear", {31'd0, kif.KEY_EVENT[2]}, 32'd0);
        chk("race_others", kif.KEY_EVENT, 4'h3);
        kif.KEY_RAW = 4'hF;
        ticks(8);
        chk("k2_released", kif.KEY_OUT, 4'h0);

        // Reset mid-count on key 3
        kif.KEY_RAW = 4'b0111;
        ticks(4);
        RST_N = 1'b0;
        #2;
        chk("mid_rst_out", kif.KEY_OUT, 4'h0);
        chk("mid_rst_event", kif.KEY_EVENT, 4'h0);
        tick();
        RST_N = 1'b1;
        acc = 4'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc = acc | kif.KEY_OUT | kif.KEY_PRESS;
        end
        chk("mid_no_early", acc, 4'h0);
        tick();
        chk("mid_out", kif.KEY_OUT, 4'h8);
        chk("mid_press", kif.KEY_PRESS, 4'h8);
        tick();
        chk("mid_press_end", kif.KEY_PRESS, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
